mem_ctrl: RTL

//  Byte-serial memory controller and arbiter for the single 8-bit RAM port.

---
 rtl/mem_ctrl_if.sv | 34 +++
 rtl/mem_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Request, stall and byte-wide RAM signals shared by mem_ctrl and its requesters.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_width;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              stall_req_if;
  logic              stall_req_mem;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_width, mem_wdata, ram_din,
    output if_data, if_done, mem_rdata, mem_done, stall_req_if, stall_req_mem,
           ram_addr, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_width, mem_wdata, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, stall_req_if, stall_req_mem,
           ram_addr, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial controller arbitrating the single 8-bit RAM port between
// instruction fetch (4-byte reads) and the MEM stage (1/2/4-byte loads/stores).
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic              owner_mem;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;

  logic [CNT_W-1:0]  mem_len_c;
  logic [31:0]       rbyte_c;
  logic [31:0]       wsel_c;
  logic [7:0]        wbyte_c;

  assign bus.stall_req_if  = bus.if_req  & ~bus.if_done;
  assign bus.stall_req_mem = bus.mem_req & ~bus.mem_done;

  // Byte count decode; anything other than 1 or 2 is a full word.
  always_comb begin
    mem_len_c = CNT_W'(4);
    case (bus.mem_width)
      4'd1:    mem_len_c = CNT_W'(1);
      4'd2:    mem_len_c = CNT_W'(2);
      default: mem_len_c = CNT_W'(4);
    endcase
  end

  // Read byte arriving at edge cnt belongs to lane cnt-2; write lane is cnt.
  assign rbyte_c = 32'(bus.ram_din) << {cnt[1:0] - 2'd2, 3'b000};
  assign wsel_c  = wdata >> {cnt[1:0], 3'b000};
  assign wbyte_c = wsel_c[7:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      owner_mem     <= 1'b0;
      base          <= '0;
      len           <= '0;
      cnt           <= '0;
      wdata         <= '0;
      rbuf          <= '0;
      bus.ram_addr  <= '0;
      bus.ram_dout  <= '0;
      bus.ram_wr    <= 1'b0;
      bus.if_done   <= 1'b0;
      bus.mem_done  <= 1'b0;
      bus.if_data   <= '0;
      bus.mem_rdata <= '0;
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      bus.ram_wr   <= 1'b0;
      cnt          <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          cnt  <= CNT_W'(1);
          rbuf <= '0;
          // MEM is the older instruction, so it wins the port.
          if (bus.mem_req) begin
            owner_mem    <= 1'b1;
            base         <= bus.mem_addr;
            len          <= mem_len_c;
            wdata        <= bus.mem_wdata;
            bus.ram_addr <= bus.mem_addr;
            if (bus.mem_we) begin
              state        <= WRITE;
              bus.ram_wr   <= 1'b1;
              bus.ram_dout <= bus.mem_wdata[7:0];
            end else begin
              state <= READ;
            end
          end else if (bus.if_req) begin
            owner_mem    <= 1'b0;
            base         <= bus.if_addr;
            len          <= CNT_W'(4);
            bus.ram_addr <= bus.if_addr;
            state        <= READ;
          end
        end
        READ: begin
          if (cnt < len) begin
            bus.ram_addr <= base + ADDR_W'(cnt);
          end
          if (cnt >= CNT_W'(2)) begin
            rbuf <= rbuf | rbyte_c;
          end
          if (cnt == len + CNT_W'(1)) begin
            state <= DONE;
            if (owner_mem) begin
              bus.mem_done  <= 1'b1;
              bus.mem_rdata <= rbuf | rbyte_c;
            end else begin
              bus.if_done <= 1'b1;
              bus.if_data <= rbuf | rbyte_c;
            end
          end
        end
        WRITE: begin
          if (cnt < len) begin
            bus.ram_wr   <= 1'b1;
            bus.ram_addr <= base + ADDR_W'(cnt);
            bus.ram_dout <= wbyte_c;
          end else begin
            state        <= DONE;
            bus.mem_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
